opp_rx_latch: RTL and testbench



---
 rtl/opp_pkg.sv | 45 ++++
 rtl/opp_rx_check.sv | 53 +++++
 rtl/opp_rx_latch.sv | 158 +++++++++++++++
 tb/tb_opp_rx_latch.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/opp_pkg.sv
// opp_pkg -- shared definitions for the opponent-state link.
//   opp_state_t   : committed/pending opponent state (x, y, dir, game)
//   *_LSB / *_W   : payload field positions, identical to the transmit packer
//   *_MAX_DEF     : default acceptance limits for the receive range check
//   pack_payload  : builds a 44-bit payload word (transmit side / models)
package opp_pkg;

  localparam int PAYLOAD_W   = 44;

  // Payload layout. Bits 32, 20, 10:8, 4 and 2:0 are reserved.
  localparam int X_LSB    = 33;
  localparam int X_W      = 11;
  localparam int Y_LSB    = 21;
  localparam int Y_W      = 11;
  localparam int DIR_LSB  = 11;
  localparam int DIR_W    = 9;
  localparam int GAME_LSB = 5;
  localparam int GAME_W   = 3;
  localparam int RST_BIT  = 3;

  localparam int H_MAX_DEF   = 1024;
  localparam int V_MAX_DEF   = 768;
  localparam int DIR_MAX_DEF = 360;

  typedef struct packed {
    logic [X_W-1:0]    x;
    logic [Y_W-1:0]    y;
    logic [DIR_W-1:0]  dir;
    logic [GAME_W-1:0] game;
  } opp_state_t;

  // Reserved bits are sent as zero.
  function automatic logic [PAYLOAD_W-1:0] pack_payload(input opp_state_t s,
                                                        input logic rst_flag);
    logic [PAYLOAD_W-1:0] w;
    w = '0;
    w[X_LSB    +: X_W]    = s.x;
    w[Y_LSB    +: Y_W]    = s.y;
    w[DIR_LSB  +: DIR_W]  = s.dir;
    w[GAME_LSB +: GAME_W] = s.game;
    w[RST_BIT]            = rst_flag;
    return w;
  endfunction

endpackage

// File: rtl/opp_rx_check.sv
// opp_rx_check -- stage 1 of the opponent receive path.
// Registers the payload fields on axiiv, then range-checks the registered
// copy so that the wide comparators never sit on the raw input path.
// Ports:
//   clk_in, rst_in : pixel clock, synchronous active-high reset
//   axiiv, axiid   : payload valid pulse and 44-bit payload word
//   s1_vld         : stage-1 holds a freshly captured packet this cycle
//   s1_st          : decoded opponent state
//   s1_rst         : opponent reset-request flag
//   s1_good        : all fields inside their acceptance limits
module opp_rx_check
  import opp_pkg::*;
#(
  parameter int H_MAX   = H_MAX_DEF,
  parameter int V_MAX   = V_MAX_DEF,
  parameter int DIR_MAX = DIR_MAX_DEF
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 axiiv,
  input  logic [PAYLOAD_W-1:0] axiid,
  output logic                 s1_vld,
  output opp_state_t           s1_st,
  output logic                 s1_rst,
  output logic                 s1_good
);

  // Reserved payload bits are deliberately dropped.
  logic unused_rsvd;
  assign unused_rsvd = ^{axiid[32], axiid[20], axiid[10:8], axiid[4], axiid[2:0]};

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_vld <= 1'b0;
      s1_st  <= '0;
      s1_rst <= 1'b0;
    end else begin
      s1_vld <= axiiv;
      if (axiiv) begin
        s1_st.x    <= axiid[X_LSB    +: X_W];
        s1_st.y    <= axiid[Y_LSB    +: Y_W];
        s1_st.dir  <= axiid[DIR_LSB  +: DIR_W];
        s1_st.game <= axiid[GAME_LSB +: GAME_W];
        s1_rst     <= axiid[RST_BIT];
      end
    end
  end

  assign s1_good = (32'(s1_st.x)   < H_MAX) &&
                   (32'(s1_st.y)   < V_MAX) &&
                   (32'(s1_st.dir) < DIR_MAX);

endmodule

// File: rtl/opp_rx_latch.sv
// opp_rx_latch -- opponent state receiver in the 65 MHz pixel domain.
// Decodes the opponent payload, drops out-of-range packets, keeps the most
// recent good state pending and commits it to the outputs once per frame
// (first blanking line) so sprites never tear. Link liveness is a frame
// count since the last good packet.
// Optional build macro OPP_RX_STATS_EN adds saturating packet counters.
// Ports:
//   clk_in, rst_in       : pixel clock, synchronous active-high reset
//   hcount_in, vcount_in : VGA raster position
//   axiiv, axiid         : payload valid pulse and payload word
//   opp_x/y/dir/game     : committed opponent state
//   opp_valid            : committed state came from a live link
//   opp_rst_pulse        : one-cycle opponent reset request (not frame aligned)
//   link_up              : good packet seen within TIMEOUT_FRAMES frames
//   good_cnt/bad_cnt/drop_cnt (OPP_RX_STATS_EN only): packet statistics
module opp_rx_latch
  import opp_pkg::*;
#(
  parameter int H_MAX          = H_MAX_DEF,
  parameter int V_MAX          = V_MAX_DEF,
  parameter int DIR_MAX        = DIR_MAX_DEF,
  parameter int V_COMMIT       = 768,
  parameter int TIMEOUT_FRAMES = 30,
  parameter int TO_W           = 6
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] hcount_in,
  input  logic [9:0]  vcount_in,
  input  logic        axiiv,
  input  logic [43:0] axiid,
  output logic [10:0] opp_x,
  output logic [10:0] opp_y,
  output logic [8:0]  opp_dir,
  output logic [2:0]  opp_game,
  output logic        opp_valid,
  output logic        opp_rst_pulse,
  output logic        link_up
`ifdef OPP_RX_STATS_EN
  ,
  output logic [15:0] good_cnt,
  output logic [15:0] bad_cnt,
  output logic [15:0] drop_cnt
`endif
);

  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_FRAMES);

  // ---------------- stage 1: decode + range check ----------------
  logic       s1_vld;
  opp_state_t s1_st;
  logic       s1_rst;
  logic       s1_good;

  opp_rx_check #(
    .H_MAX   (H_MAX),
    .V_MAX   (V_MAX),
    .DIR_MAX (DIR_MAX)
  ) u_check (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .axiiv   (axiiv),
    .axiid   (axiid),
    .s1_vld  (s1_vld),
    .s1_st   (s1_st),
    .s1_rst  (s1_rst),
    .s1_good (s1_good)
  );

  // ---------------- stage 2 / commit / timeout ----------------
  logic            s2_load;
  logic            frame_tick;
  opp_state_t      pend;
  logic            pend_full;
  opp_state_t      cur;
  logic [TO_W-1:0] to_cnt;
  logic [TO_W-1:0] to_nxt;
  logic            to_hit;

  assign s2_load = s1_vld & s1_good;

  // Saturating next value; a same-cycle good packet clears instead, so the
  // link can only time out on a tick with no good packet in stage 2.
  assign to_nxt = (to_cnt == TO_MAX) ? TO_MAX : to_cnt + 1'b1;
  assign to_hit = frame_tick && !s2_load && (to_nxt == TO_MAX);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      frame_tick    <= 1'b0;
      pend          <= '0;
      pend_full     <= 1'b0;
      cur           <= '0;
      opp_valid     <= 1'b0;
      opp_rst_pulse <= 1'b0;
      link_up       <= 1'b0;
      to_cnt        <= TO_MAX;
    end else begin
      frame_tick    <= (hcount_in == '0) && (vcount_in == 10'(V_COMMIT));
      opp_rst_pulse <= s2_load & s1_rst;

      // Commit reads the pre-load pending value; a packet landing on the
      // tick cycle stays pending for the next frame.
      if (frame_tick && pend_full)
        cur <= pend;

      if (s2_load)
        pend <= s1_st;

      if (s2_load)
        pend_full <= 1'b1;
      else if (frame_tick)
        pend_full <= 1'b0;

      if (s2_load)
        to_cnt <= '0;
      else if (frame_tick)
        to_cnt <= to_nxt;

      if (s2_load)
        link_up <= 1'b1;
      else if (to_hit)
        link_up <= 1'b0;

      if (to_hit)
        opp_valid <= 1'b0;
      else if (frame_tick && pend_full)
        opp_valid <= link_up;
    end
  end

  assign opp_x    = cur.x;
  assign opp_y    = cur.y;
  assign opp_dir  = cur.dir;
  assign opp_game = cur.game;

`ifdef OPP_RX_STATS_EN
  // A pending value counts as dropped only if it is overwritten without
  // having been committed on this same cycle.
  logic s2_bad;
  logic s2_drop;

  assign s2_bad  = s1_vld & ~s1_good;
  assign s2_drop = s2_load & pend_full & ~frame_tick;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
      drop_cnt <= '0;
    end else begin
      if (s2_load && good_cnt != '1) good_cnt <= good_cnt + 1'b1;
      if (s2_bad  && bad_cnt  != '1) bad_cnt  <= bad_cnt  + 1'b1;
      if (s2_drop && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_opp_rx_latch.sv
module tb_opp_rx_latch;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = 11'd5;
  logic [9:0]  vcount_in = 10'd10;
  logic        axiiv = 1'b0;
  logic [43:0] axiid = '0;
  logic [10:0] opp_x;
  logic [10:0] opp_y;
  logic [8:0]  opp_dir;
  logic [2:0]  opp_game;
  logic        opp_valid;
  logic        opp_rst_pulse;
  logic        link_up;
`ifdef OPP_RX_STATS_EN
  logic [15:0] good_cnt;
  logic [15:0] bad_cnt;
  logic [15:0] drop_cnt;
`endif

  opp_rx_latch dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .axiiv         (axiiv),
    .axiid         (axiid),
    .opp_x         (opp_x),
    .opp_y         (opp_y),
    .opp_dir       (opp_dir),
    .opp_game      (opp_game),
    .opp_valid     (opp_valid),
    .opp_rst_pulse (opp_rst_pulse),
    .link_up       (link_up)
`ifdef OPP_RX_STATS_EN
    ,
    .good_cnt      (good_cnt),
    .bad_cnt       (bad_cnt),
    .drop_cnt      (drop_cnt)
`endif
  );

  always #8 clk_in = ~clk_in;

  typedef struct {
    int x, y, dir, game, valid, link;
  } exp_t;

  exp_t exp_q[$];
  int   pulse_q[$];
  int   cyc;
  int   vec_cnt;
  int   err_cnt;

  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    vec_cnt++;
    if (got !== want) begin
      err_cnt++;
      $display("FAIL %s: got %0d want %0d", tag, got, want);
    end
  endtask

  // Reserved bits driven high so the decoder must ignore them.
  function automatic logic [43:0] mk(input int x, input int y, input int dir,
                                     input int game, input bit rf);
    logic [43:0] w;
    w         = '0;
    w[43:33]  = x[10:0];
    w[32]     = 1'b1;
    w[31:21]  = y[10:0];
    w[20]     = 1'b1;
    w[19:11]  = dir[8:0];
    w[10:8]   = 3'b111;
    w[7:5]    = game[2:0];
    w[4]      = 1'b1;
    w[3]      = rf;
    w[2:0]    = 3'b111;
    return w;
  endfunction

  function automatic bit in_range(input int x, input int y, input int dir);
    return (x < 1024) && (y < 768) && (dir < 360);
  endfunction

  // Any pulse must match a queued expectation at exactly its cycle.
  always @(negedge clk_in) begin
    if (opp_rst_pulse === 1'b1) begin
      if (pulse_q.size() == 0) chk("rst_pulse_unexpected", 32'd1, 32'd0);
      else                     chk("rst_pulse_cycle", cyc, pulse_q.pop_front());
    end
  end

  task automatic drive_pkt(input int x, input int y, input int dir,
                           input int game, input bit rf);
    axiid = mk(x, y, dir, game, rf);
    axiiv = 1'b1;
    if (rf && in_range(x, y, dir)) pulse_q.push_back(cyc + 2);
  endtask

  task automatic send(input int x, input int y, input int dir,
                      input int game, input bit rf);
    @(negedge clk_in);
    drive_pkt(x, y, dir, game, rf);
    @(negedge clk_in);
    axiiv = 1'b0;
    repeat (2) @(negedge clk_in);
  endtask

  task automatic expect_commit(input int x, input int y, input int dir,
                               input int game, input int valid, input int link);
    exp_t e;
    e.x = x; e.y = y; e.dir = dir; e.game = game; e.valid = valid; e.link = link;
    exp_q.push_back(e);
  endtask

  task automatic compare_commit(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk({tag, "_no_expect"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk({tag, "_x"},     opp_x,     e.x);
      chk({tag, "_y"},     opp_y,     e.y);
      chk({tag, "_dir"},   opp_dir,   e.dir);
      chk({tag, "_game"},  opp_game,  e.game);
      chk({tag, "_valid"}, opp_valid, e.valid);
      chk({tag, "_link"},  link_up,   e.link);
    end
  endtask

  task automatic tick(input string tag);
    @(negedge clk_in);
    hcount_in = 11'd0; vcount_in = 10'd768;
    @(negedge clk_in);
    hcount_in = 11'd5; vcount_in = 10'd10;
    @(negedge clk_in);
    compare_commit(tag);
  endtask

  // Packet stage 2 coincides with the registered frame tick.
  task automatic tick_with_pkt(input string tag, input int x, input int y,
                               input int dir, input int game);
    @(negedge clk_in);
    drive_pkt(x, y, dir, game, 1'b0);
    hcount_in = 11'd0; vcount_in = 10'd768;
    @(negedge clk_in);
    axiiv = 1'b0;
    hcount_in = 11'd5; vcount_in = 10'd10;
    @(negedge clk_in);
    compare_commit(tag);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_x"},     opp_x,         0);
    chk({tag, "_y"},     opp_y,         0);
    chk({tag, "_dir"},   opp_dir,       0);
    chk({tag, "_game"},  opp_game,      0);
    chk({tag, "_valid"}, opp_valid,     0);
    chk({tag, "_pulse"}, opp_rst_pulse, 0);
    chk({tag, "_link"},  link_up,       0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk_in);
    check_all_zero("reset");
    rst_in = 1'b0;
    repeat (2) @(negedge clk_in);

    // Good packet mid-frame: outputs wait for the tick, link comes up at once.
    send(100, 200, 90, 1, 1'b0);
    chk("pre_tick_x", opp_x, 0);
    chk("pre_tick_valid", opp_valid, 0);
    chk("link_up_early", link_up, 1);
    expect_commit(100, 200, 90, 1, 1, 1);
    tick("first_commit");

    // Range rejects, including each limit exactly.
    send(1100, 5, 5, 0, 1'b0);
`ifdef OPP_RX_STATS_EN
    chk("bad_cnt_first", bad_cnt, 1);
`endif
    send(10, 768, 0, 2, 1'b0);
    send(10, 0, 360, 3, 1'b0);
    chk("bad_link", link_up, 1);
    expect_commit(100, 200, 90, 1, 1, 1);
    tick("bad_hold");

    // Largest accepted values.
    send(1023, 767, 359, 7, 1'b0);
    expect_commit(1023, 767, 359, 7, 1, 1);
    tick("max_commit");

    // Reset request: pulse 2 cycles after axiiv; a bad packet must not pulse.
    send(5, 6, 7, 2, 1'b1);
    send(2000, 0, 0, 0, 1'b1);
    expect_commit(5, 6, 7, 2, 1, 1);
    tick("rst_req_commit");

    // Last one wins within a frame.
    send(10, 11, 12, 3, 1'b0);
    send(20, 21, 22, 4, 1'b0);
    send(30, 31, 32, 5, 1'b0);
    expect_commit(30, 31, 32, 5, 1, 1);
    tick("last_wins");

    // Load on the tick cycle: 40 commits now, 50 next frame.
    send(40, 41, 42, 6, 1'b0);
    expect_commit(40, 41, 42, 6, 1, 1);
    tick_with_pkt("collide_old", 50, 51, 52, 0);
    expect_commit(50, 51, 52, 0, 1, 1);
    tick("collide_new");
`ifdef OPP_RX_STATS_EN
    chk("good_cnt", good_cnt, 8);
    chk("bad_cnt", bad_cnt, 4);
    chk("drop_cnt", drop_cnt, 2);
`endif

    // Silence: the link drops on the 30th tick, position holds.
    send(77, 78, 79, 1, 1'b0);
    for (int i = 1; i <= 30; i++) begin
      expect_commit(77, 78, 79, 1, (i < 30) ? 1 : 0, (i < 30) ? 1 : 0);
      tick($sformatf("timeout_t%0d", i));
    end

    // One-cycle reset clears everything.
    @(negedge clk_in);
    rst_in = 1'b1;
    @(negedge clk_in);
    check_all_zero("reset_mid");
    rst_in = 1'b0;
`ifdef OPP_RX_STATS_EN
    chk("stats_cleared", {good_cnt, bad_cnt}, 0);
`endif

    // Reset while a packet is in stage 1: it must vanish without a pulse.
    @(negedge clk_in);
    axiid = mk(9, 9, 9, 1, 1'b1);
    axiiv = 1'b1;
    @(negedge clk_in);
    axiiv  = 1'b0;
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    repeat (3) @(negedge clk_in);
    expect_commit(0, 0, 0, 0, 0, 0);
    tick("inflight_discard");

    chk("pulse_q_drained", pulse_q.size(), 0);
    chk("exp_q_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
